matrix_scroll_buffer: RTL and testbench

- Upstream feeder for the 5x7 LED matrix column scanner.
- Accepts a stream of 7-bit column bitmaps over a valid/ready handshake and buffers them in a small FIFO.
- Shifts the columns right-to-left through a 5-column display window at a programmable scroll rate.
- Presents the window as column_4..column_0, the parallel column inputs of the column scanner.

---
 rtl/matrix_scroll_buffer.sv | 179 +++++++++++++++++
 tb/tb_matrix_scroll_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scroll_buffer.sv
// rtl/matrix_scroll_buffer.sv - column FIFO and scrolling 5-column window feeding the LED matrix column scanner
//
// Purpose:
//   Buffers 7-bit column bitmaps from a valid/ready stream in a small FIFO and
//   shifts them right-to-left through a 5-column display window, one column per
//   prescaler tick. A column tagged "last" is followed by five blank columns so
//   the message scrolls fully off before the block goes idle again.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_column[6:0]    column bitmap to enqueue
//   in_valid, in_last entry valid / final column of a message
//   in_ready          FIFO has room this cycle (combinational)
//   scroll_enable     prescaler advances only while high
//   pause             (MATRIX_SCROLL_PAUSE_EN only) freezes scrolling in SCROLL/DRAIN
//   column_4..0       display window, column_4 oldest, column_0 newest
//   busy              block is scrolling or draining
//   fifo_level        current FIFO occupancy
//
// Optional feature macro: MATRIX_SCROLL_PAUSE_EN

module matrix_scroll_buffer #(
    parameter int         SCROLL_DIV   = 25000000,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [6:0] BLANK_COLUMN = 7'b1111111
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [6:0]                    in_column,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          scroll_enable,
`ifdef MATRIX_SCROLL_PAUSE_EN
    input  logic                          pause,
`endif
    output logic [6:0]                    column_4,
    output logic [6:0]                    column_3,
    output logic [6:0]                    column_2,
    output logic [6:0]                    column_1,
    output logic [6:0]                    column_0,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           drain_q, drain_d;
    logic [4:0][6:0]      win_q, win_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [7:0]           fifo_mem_q [FIFO_DEPTH];

    logic                 pause_int;
    logic                 active;
    logic                 advance;
    logic                 tick;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [7:0]           head;

`ifdef MATRIX_SCROLL_PAUSE_EN
    assign pause_int = pause;
`else
    assign pause_int = 1'b0;
`endif

    assign in_ready   = (level_q < LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign head       = fifo_mem_q[rd_ptr_q];
    assign push       = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        win_d    = win_q;
        pop      = 1'b0;

        active  = (state_q != ST_IDLE);
        advance = active && scroll_enable && !pause_int;
        tick    = advance && (cnt_q == CNT_W'(SCROLL_DIV - 1));

        // Prescaler is held (not cleared) while disabled or paused.
        if (!active) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_SCROLL;
                end
            end
            ST_SCROLL: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        win_d = {win_q[3:0], head[6:0]};
                        if (head[7]) begin
                            state_d = ST_DRAIN;
                            drain_d = 3'd0;
                        end
                    end else begin
                        // Underrun: keep scrolling with a gap rather than stalling.
                        win_d = {win_q[3:0], BLANK_COLUMN};
                    end
                end
            end
            ST_DRAIN: begin
                if (tick) begin
                    win_d = {win_q[3:0], BLANK_COLUMN};
                    if (drain_q == 3'd4) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drain_q  <= '0;
            win_q    <= {5{BLANK_COLUMN}};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            fifo_mem_q[wr_ptr_q] <= {in_last, in_column};
        end
    end

    assign column_4   = win_q[4];
    assign column_3   = win_q[3];
    assign column_2   = win_q[2];
    assign column_1   = win_q[1];
    assign column_0   = win_q[0];
    assign busy       = (state_q != ST_IDLE);
    assign fifo_level = level_q;

endmodule

// File: tb/tb_matrix_scroll_buffer.sv
// tb/tb_matrix_scroll_buffer.sv - directed self-checking bench for matrix_scroll_buffer

module tb_matrix_scroll_buffer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] in_column = 7'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       scroll_enable = 1'b0;
`ifdef MATRIX_SCROLL_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [6:0] column_4, column_3, column_2, column_1, column_0;
    logic       busy;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    matrix_scroll_buffer #(
        .SCROLL_DIV  (4),
        .FIFO_DEPTH  (4),
        .BLANK_COLUMN(7'b1111111)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_column    (in_column),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .scroll_enable(scroll_enable),
`ifdef MATRIX_SCROLL_PAUSE_EN
        .pause        (pause),
`endif
        .column_4     (column_4),
        .column_3     (column_3),
        .column_2     (column_2),
        .column_1     (column_1),
        .column_0     (column_0),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    task automatic push_col(input logic [6:0] c, input logic last);
        in_valid  = 1'b1;
        in_column = c;
        in_last   = last;
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        scroll_enable = 1'b0;
        do_reset();
        checks++;
        if ({column_4, column_3, column_2, column_1, column_0} !== {5{7'h7F}}) begin
            $display("FAIL reset_window: got %h expected %h",
                     {column_4, column_3, column_2, column_1, column_0}, {5{7'h7F}});
            errors++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
            errors++;
        end
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b expected 0", busy);
            errors++;
        end
        checks++;
        if (fifo_level !== 3'd0) begin
            $display("FAIL reset_level: got %0d expected 0", fifo_level);
            errors++;
        end
    endtask

    task automatic test_message();
        do_reset();
        scroll_enable = 1'b1;
        push_col(7'h01, 1'b0);
        push_col(7'h02, 1'b0);
        push_col(7'h03, 1'b1);
        step(2);
        checks++;
        if (column_0 !== 7'h7F) begin
            $display("FAIL msg_pre_tick: got %h expected 7f", column_0);
            errors++;
        end
        step(1);
        checks++;
        if (column_0 !== 7'h01) begin
            $display("FAIL msg_tick1: got %h expected 01", column_0);
            errors++;
        end
        step(3);
        checks++;
        if (column_0 !== 7'h01) begin
            $display("FAIL msg_hold: got %h expected 01", column_0);
            errors++;
        end
        step(1);
        checks++;
        if ({column_1, column_0} !== {7'h01, 7'h02}) begin
            $display("FAIL msg_tick2: got %h expected %h", {column_1, column_0}, {7'h01, 7'h02});
            errors++;
        end
        step(4);
        checks++;
        if ({column_2, column_1, column_0} !== {7'h01, 7'h02, 7'h03}) begin
            $display("FAIL msg_tick3: got %h expected %h",
                     {column_2, column_1, column_0}, {7'h01, 7'h02, 7'h03});
            errors++;
        end
        step(16);
        checks++;
        if ({busy, column_4, column_0} !== {1'b1, 7'h03, 7'h7F}) begin
            $display("FAIL drain_4th: got %h expected %h", {busy, column_4, column_0}, {1'b1, 7'h03, 7'h7F});
            errors++;
        end
        step(4);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL drain_busy: got %b expected 0", busy);
            errors++;
        end
        checks++;
        if ({column_4, column_3, column_2, column_1, column_0} !== {5{7'h7F}}) begin
            $display("FAIL drain_window: got %h expected %h",
                     {column_4, column_3, column_2, column_1, column_0}, {5{7'h7F}});
            errors++;
        end
    endtask

    task automatic test_full();
        do_reset();
        scroll_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_col(7'h11 + 7'(i), 1'b0);
        end
        checks++;
        if ({in_ready, fifo_level} !== {1'b0, 3'd4}) begin
            $display("FAIL full_flags: got ready=%b level=%0d expected ready=0 level=4", in_ready, fifo_level);
            errors++;
        end
        in_valid  = 1'b1;
        in_column = 7'h15;
        step(2);
        checks++;
        if (fifo_level !== 3'd4) begin
            $display("FAIL full_hold: got %0d expected 4", fifo_level);
            errors++;
        end
        scroll_enable = 1'b1;
        step(3);
        checks++;
        if (fifo_level !== 3'd4) begin
            $display("FAIL full_pre_pop: got %0d expected 4", fifo_level);
            errors++;
        end
        step(1);
        checks++;
        if ({column_0, fifo_level, in_ready} !== {7'h11, 3'd3, 1'b1}) begin
            $display("FAIL full_pop: got c0=%h level=%0d ready=%b expected c0=11 level=3 ready=1",
                     column_0, fifo_level, in_ready);
            errors++;
        end
        step(1);
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4) begin
            $display("FAIL full_accept5: got %0d expected 4", fifo_level);
            errors++;
        end
    endtask

    task automatic test_underrun();
        do_reset();
        scroll_enable = 1'b1;
        push_col(7'h2A, 1'b0);
        step(5);
        checks++;
        if (column_0 !== 7'h2A) begin
            $display("FAIL underrun_first: got %h expected 2a", column_0);
            errors++;
        end
        step(4);
        checks++;
        if ({busy, column_1, column_0} !== {1'b1, 7'h2A, 7'h7F}) begin
            $display("FAIL underrun_blank: got %h expected %h", {busy, column_1, column_0}, {1'b1, 7'h2A, 7'h7F});
            errors++;
        end
    endtask

    task automatic test_enable_gap();
        do_reset();
        scroll_enable = 1'b1;
        push_col(7'h33, 1'b0);
        push_col(7'h34, 1'b0);
        step(4);
        checks++;
        if (column_0 !== 7'h33) begin
            $display("FAIL gap_first: got %h expected 33", column_0);
            errors++;
        end
        step(2);
        scroll_enable = 1'b0;
        step(10);
        checks++;
        if (column_0 !== 7'h33) begin
            $display("FAIL gap_frozen: got %h expected 33", column_0);
            errors++;
        end
        scroll_enable = 1'b1;
        step(1);
        checks++;
        if (column_0 !== 7'h33) begin
            $display("FAIL gap_early: got %h expected 33", column_0);
            errors++;
        end
        step(1);
        checks++;
        if (column_0 !== 7'h34) begin
            $display("FAIL gap_resume: got %h expected 34", column_0);
            errors++;
        end
    endtask

`ifdef MATRIX_SCROLL_PAUSE_EN
    task automatic test_pause();
        do_reset();
        scroll_enable = 1'b1;
        push_col(7'h41, 1'b0);
        push_col(7'h42, 1'b0);
        step(4);
        step(1);
        pause = 1'b1;
        step(5);
        push_col(7'h44, 1'b0);
        step(14);
        checks++;
        if ({column_0, fifo_level} !== {7'h41, 3'd2}) begin
            $display("FAIL pause_hold: got c0=%h level=%0d expected c0=41 level=2", column_0, fifo_level);
            errors++;
        end
        pause = 1'b0;
        step(2);
        checks++;
        if (column_0 !== 7'h41) begin
            $display("FAIL pause_early: got %h expected 41", column_0);
            errors++;
        end
        step(1);
        checks++;
        if (column_0 !== 7'h42) begin
            $display("FAIL pause_resume: got %h expected 42", column_0);
            errors++;
        end
    endtask
`endif

    task automatic test_reset_mid_drain();
        do_reset();
        scroll_enable = 1'b1;
        push_col(7'h55, 1'b1);
        step(5);
        checks++;
        if ({busy, column_0} !== {1'b1, 7'h55}) begin
            $display("FAIL middrain_setup: got %h expected %h", {busy, column_0}, {1'b1, 7'h55});
            errors++;
        end
        push_col(7'h66, 1'b0);
        step(1);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_column = 7'h77;
        step(1);
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({column_4, column_3, column_2, column_1, column_0} !== {5{7'h7F}}) begin
            $display("FAIL middrain_window: got %h expected %h",
                     {column_4, column_3, column_2, column_1, column_0}, {5{7'h7F}});
            errors++;
        end
        checks++;
        if ({busy, in_ready, fifo_level} !== {1'b0, 1'b1, 3'd0}) begin
            $display("FAIL middrain_flags: got busy=%b ready=%b level=%0d expected 0 1 0",
                     busy, in_ready, fifo_level);
            errors++;
        end
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL middrain_stay_idle: got %b expected 0", busy);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_message();
        test_full();
        test_underrun();
        test_enable_gap();
`ifdef MATRIX_SCROLL_PAUSE_EN
        test_pause();
`endif
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
